switch_read_ctrl: RTL

//  Controller in front of the 24 board switches. Synchronises and debounces switch_i
//  and holds a stable snapshot. Raises a change event/interrupt flag.

---
 rtl/switch_read_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/switch_read_ctrl.sv
// Debounced switch snapshot with change irq and a req/ack
// read port onto the 16-bit I/O data bus.
module switch_read_ctrl #(
  parameter int SW_WIDTH        = 24,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  logic                swclk,
  input  logic                swrst_n,
  input  logic [SW_WIDTH-1:0] switch_i,
  input  logic                rd_req,
  input  logic [1:0]          rd_addr,
  output logic                rd_ack,
  output logic [15:0]         rd_data,
  input  logic                irq_clr,
  output logic [SW_WIDTH-1:0] sw_stable,
  output logic                sw_changed,
  output logic                irq_pending
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CAP  = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [SW_WIDTH-1:0] sync1;
  logic [SW_WIDTH-1:0] sync2;
  logic [SW_WIDTH-1:0] cand;
  logic [CNT_W-1:0]    cnt;
  logic [1:0]          state;
  logic [1:0]          addr_q;
  logic [15:0]         rd_mux;
  logic                upd;
  logic                ack_rd01;

  assign upd      = (cnt == CNT_MAX) && (cand != sw_stable);
  assign ack_rd01 = (state == S_ACK) && (addr_q == 2'b01);

  always_ff @(posedge swclk or negedge swrst_n) begin
    if (!swrst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= switch_i;
      sync2 <= sync1;
    end
  end

  // cnt saturates so a long-steady input keeps qualifying
  always_ff @(posedge swclk or negedge swrst_n) begin
    if (!swrst_n) begin
      cand <= '0;
      cnt  <= '0;
    end else if (sync2 != cand) begin
      cand <= sync2;
      cnt  <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt  <= cnt + 1'b1;
    end
  end

  always_ff @(posedge swclk or negedge swrst_n) begin
    if (!swrst_n) begin
      sw_stable  <= '0;
      sw_changed <= 1'b0;
    end else begin
      sw_changed <= upd;
      if (upd) sw_stable <= cand;
    end
  end

  always_ff @(posedge swclk or negedge swrst_n) begin
    if (!swrst_n)
      irq_pending <= 1'b0;
    else if (sw_changed)
      irq_pending <= 1'b1;
    else if (irq_clr || ack_rd01)
      irq_pending <= 1'b0;
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      addr_q == 2'b00: rd_mux = sw_stable[15:0];
      addr_q == 2'b10: rd_mux = {8'h00, sw_stable[23:16]};
      addr_q == 2'b01: rd_mux = {15'b0, irq_pending};
      default:         rd_mux = '0;
    endcase
  end

  always_ff @(posedge swclk or negedge swrst_n) begin
    if (!swrst_n) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      rd_data <= '0;
      rd_ack  <= 1'b0;
    end else begin
      rd_ack <= (state == S_ACK);
      unique case (state)
        S_IDLE: begin
          if (rd_req) begin
            addr_q <= rd_addr;
            state  <= S_CAP;
          end
        end
        S_CAP: begin
          rd_data <= rd_mux;
          state   <= S_ACK;
        end
        S_ACK:  state <= S_HOLD;
        S_HOLD: if (!rd_req) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
